// File: rtl/leaf_pkg.sv
// rtl/leaf_pkg.sv - shared packet layout, FSM states and credit constants for the leaf output packetizer
package leaf_pkg;

    // Packet layout for the default geometry (5-bit leaf, 4-bit port, 7-bit addr, 32-bit payload)
    localparam int VALID_BIT = 48;
    localparam int LEAF_MSB  = 47;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_MSB  = 42;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_MSB  = 38;
    localparam int ADDR_LSB  = 32;

    // Credit available out of reset and the ceiling credit saturates at
    localparam int MAX_CREDIT = 128;

    typedef enum logic [1:0] {
        UNCFG       = 2'd0,
        RUN         = 2'd1,
        CREDIT_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/leaf_pkt_fifo2.sv
// rtl/leaf_pkt_fifo2.sv - two-entry packet FIFO with occupancy count
module leaf_pkt_fifo2 #(
    parameter int WIDTH = 49
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop_ok;
    logic             push_ok;

    // Pops on an empty FIFO and pushes into a full one that is not draining are ignored
    always_comb begin
        pop_ok  = pop & (count != 2'd0);
        push_ok = push & ((count != 2'd2) | pop_ok);
    end

    // Head register always holds the oldest entry; tail holds the second one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Present zero while empty so the downstream bus is quiet
    always_comb begin
        pop_data = (count != 2'd0) ? head : '0;
    end

endmodule

// File: rtl/leaf_out_packetizer.sv
// rtl/leaf_out_packetizer.sv - wraps HLS operator output words into credit-gated BFT packets
module leaf_out_packetizer #(
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk_user,
    input  logic                     reset,
    input  logic [PAYLOAD_BITS-1:0]  din,
    input  logic                     din_vld,
    output logic                     din_ack,
    input  logic                     cfg_wr,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
    input  logic                     credit_upd,
    output logic [PACKET_BITS-1:0]   pkt_out,
    output logic                     pkt_vld,
    input  logic                     pkt_rdy,
    output logic [NUM_ADDR_BITS:0]   credit_cnt
);

    import leaf_pkg::*;

    localparam int CW = NUM_ADDR_BITS + 1;
    localparam logic [CW-1:0] CREDIT_FULL = CW'(2 ** NUM_ADDR_BITS);
    localparam logic [CW:0]   CREDIT_FULL_EXT = (CW + 1)'(2 ** NUM_ADDR_BITS);
    localparam logic [CW:0]   UPD_INC = (CW + 1)'(FREESPACE_UPDATE_SIZE);

    state_t                   state;
    state_t                   state_next;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [CW-1:0]            credit;
    logic [CW-1:0]            credit_next;
    logic [CW:0]              credit_sum;
    logic [1:0]               fifo_count;
    logic [PACKET_BITS-1:0]   packet;
    logic                     accept;
    logic                     pop;

    // Accept only while running with credit and FIFO room; the ack is the push strobe
    always_comb begin
        accept  = din_vld & (state == RUN) & (credit != '0) & ~fifo_count[1];
        din_ack = accept;
        packet  = {1'b1, leaf, port, addr, din};
        pop     = pkt_vld & pkt_rdy;
    end

    // Net credit change for this cycle, clamped at the destination buffer size
    always_comb begin
        credit_sum = {1'b0, credit} - {{CW{1'b0}}, accept} + (credit_upd ? UPD_INC : '0);
        if (credit_sum > CREDIT_FULL_EXT) begin
            credit_next = CREDIT_FULL;
        end else begin
            credit_next = credit_sum[CW-1:0];
        end
    end

    // Control FSM next-state: stall on exhausted credit until a freespace update arrives
    always_comb begin
        state_next = state;
        case (state)
            UNCFG: begin
                if (cfg_wr) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && (credit_next == '0)) begin
                    state_next = CREDIT_WAIT;
                end
            end
            CREDIT_WAIT: begin
                if (credit_upd) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = UNCFG;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            state <= UNCFG;
        end else begin
            state <= state_next;
        end
    end

    // Destination, write address and credit bookkeeping; a relatch never rewinds the address
    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            leaf   <= '0;
            port   <= '0;
            addr   <= '0;
            credit <= CREDIT_FULL;
        end else begin
            if (cfg_wr) begin
                leaf <= cfg_dst_leaf;
                port <= cfg_dst_port;
            end
            if (accept) begin
                addr <= addr + 1'b1;
            end
            credit <= credit_next;
        end
    end

    leaf_pkt_fifo2 #(
        .WIDTH(PACKET_BITS)
    ) u_fifo (
        .clk       (clk_user),
        .rst       (reset),
        .push      (accept),
        .push_data (packet),
        .pop       (pop),
        .pop_data  (pkt_out),
        .count     (fifo_count)
    );

    // Output valid follows FIFO occupancy; debug credit mirrors the register
    always_comb begin
        pkt_vld    = (fifo_count != 2'd0);
        credit_cnt = credit;
    end

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// tb/tb_leaf_out_packetizer.sv - directed self-checking bench for leaf_out_packetizer
module tb_leaf_out_packetizer;

    import leaf_pkg::*;

    logic        clk_user = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        din_vld;
    logic        din_ack;
    logic        cfg_wr;
    logic [4:0]  cfg_dst_leaf;
    logic [3:0]  cfg_dst_port;
    logic        credit_upd;
    logic [48:0] pkt_out;
    logic        pkt_vld;
    logic        pkt_rdy;
    logic [7:0]  credit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk_user = ~clk_user;

    leaf_out_packetizer dut (
        .clk_user     (clk_user),
        .reset        (reset),
        .din          (din),
        .din_vld      (din_vld),
        .din_ack      (din_ack),
        .cfg_wr       (cfg_wr),
        .cfg_dst_leaf (cfg_dst_leaf),
        .cfg_dst_port (cfg_dst_port),
        .credit_upd   (credit_upd),
        .pkt_out      (pkt_out),
        .pkt_vld      (pkt_vld),
        .pkt_rdy      (pkt_rdy),
        .credit_cnt   (credit_cnt)
    );

    function automatic logic [48:0] mk_pkt(input logic [4:0] l, input logic [3:0] p,
                                           input logic [6:0] a, input logic [31:0] d);
        return {1'b1, l, p, a, d};
    endfunction

    task automatic tick;
        @(posedge clk_user);
        #1;
    endtask

    task automatic do_reset;
        reset        = 1'b1;
        din          = '0;
        din_vld      = 1'b0;
        cfg_wr       = 1'b0;
        cfg_dst_leaf = '0;
        cfg_dst_port = '0;
        credit_upd   = 1'b0;
        pkt_rdy      = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_cfg(input logic [4:0] l, input logic [3:0] p);
        cfg_wr       = 1'b1;
        cfg_dst_leaf = l;
        cfg_dst_port = p;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        din_vld = 1'b1;
        din     = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (din_ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_ack cyc %0d: got %b want 0", i, din_ack);
            end
            checks++;
            if (pkt_vld !== 1'b0 || pkt_out !== 49'd0) begin
                errors++;
                $display("FAIL reset_pkt cyc %0d: got vld %b out %h want 0/0", i, pkt_vld, pkt_out);
            end
            checks++;
            if (credit_cnt !== 8'd128) begin
                errors++;
                $display("FAIL reset_credit cyc %0d: got %0d want 128", i, credit_cnt);
            end
            tick();
        end
        din_vld = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        do_cfg(5'd5, 4'd3);
        pkt_rdy = 1'b1;
        din     = 32'hDEAD_BEEF;
        din_vld = 1'b1;
        #1;
        checks++;
        if (din_ack !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: got %b want 1", din_ack);
        end
        tick();
        din_vld = 1'b0;
        #1;
        checks++;
        if (pkt_vld !== 1'b1 || pkt_out !== mk_pkt(5'd5, 4'd3, 7'd0, 32'hDEAD_BEEF)) begin
            errors++;
            $display("FAIL single_pkt: got vld %b out %h want 1/%h", pkt_vld, pkt_out,
                     mk_pkt(5'd5, 4'd3, 7'd0, 32'hDEAD_BEEF));
        end
        checks++;
        if (credit_cnt !== 8'd127) begin
            errors++;
            $display("FAIL single_credit: got %0d want 127", credit_cnt);
        end
        tick();
        checks++;
        if (pkt_vld !== 1'b0 || pkt_out !== 49'd0) begin
            errors++;
            $display("FAIL single_drain: got vld %b out %h want 0/0", pkt_vld, pkt_out);
        end
    endtask

    task automatic test_stream;
        int nacc;
        int nacc2;
        int pcount;
        do_reset();
        do_cfg(5'd2, 4'd1);
        pkt_rdy = 1'b1;
        din_vld = 1'b1;
        nacc    = 0;
        pcount  = 0;
        for (int c = 0; c < 140; c++) begin
            din = 32'h1000_0000 + nacc;
            #1;
            if (pkt_vld) begin
                checks++;
                if (pkt_out[ADDR_MSB:ADDR_LSB] !== pcount[6:0] ||
                    pkt_out[31:0] !== 32'h1000_0000 + pcount) begin
                    errors++;
                    $display("FAIL stream_pkt %0d: got addr %0d data %h want %0d %h", pcount,
                             pkt_out[ADDR_MSB:ADDR_LSB], pkt_out[31:0], pcount[6:0], 32'h1000_0000 + pcount);
                end
                pcount++;
            end
            if (din_ack) nacc++;
            tick();
        end
        checks++;
        if (nacc !== 128 || pcount !== 128) begin
            errors++;
            $display("FAIL stream_count: got acc %0d pkts %0d want 128 128", nacc, pcount);
        end
        checks++;
        if (credit_cnt !== 8'd0 || din_ack !== 1'b0) begin
            errors++;
            $display("FAIL stream_wait: got credit %0d ack %b want 0 0", credit_cnt, din_ack);
        end
        credit_upd = 1'b1;
        #1;
        checks++;
        if (din_ack !== 1'b0) begin
            errors++;
            $display("FAIL stream_upd_ack: got %b want 0", din_ack);
        end
        tick();
        credit_upd = 1'b0;
        checks++;
        if (credit_cnt !== 8'd64) begin
            errors++;
            $display("FAIL stream_upd_credit: got %0d want 64", credit_cnt);
        end
        nacc2 = 0;
        for (int c = 0; c < 70; c++) begin
            din = 32'h1000_0000 + nacc;
            #1;
            if (pkt_vld) begin
                checks++;
                if (pkt_out[ADDR_MSB:ADDR_LSB] !== pcount[6:0] ||
                    pkt_out[31:0] !== 32'h1000_0000 + pcount) begin
                    errors++;
                    $display("FAIL stream2_pkt %0d: got addr %0d data %h want %0d %h", pcount,
                             pkt_out[ADDR_MSB:ADDR_LSB], pkt_out[31:0], pcount[6:0], 32'h1000_0000 + pcount);
                end
                pcount++;
            end
            if (din_ack) begin
                nacc++;
                nacc2++;
            end
            tick();
        end
        din_vld = 1'b0;
        checks++;
        if (nacc2 !== 64 || pcount !== 192 || credit_cnt !== 8'd0) begin
            errors++;
            $display("FAIL stream2_count: got acc %0d pkts %0d credit %0d want 64 192 0",
                     nacc2, pcount, credit_cnt);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        do_cfg(5'd7, 4'd2);
        pkt_rdy = 1'b0;
        din_vld = 1'b1;
        din     = 32'hAAAA_0001;
        #1;
        checks++;
        if (din_ack !== 1'b1) begin
            errors++;
            $display("FAIL bp_ack0: got %b want 1", din_ack);
        end
        tick();
        din = 32'hBBBB_0002;
        #1;
        checks++;
        if (din_ack !== 1'b1) begin
            errors++;
            $display("FAIL bp_ack1: got %b want 1", din_ack);
        end
        tick();
        din = 32'hCCCC_0003;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (din_ack !== 1'b0 || pkt_vld !== 1'b1 ||
                pkt_out !== mk_pkt(5'd7, 4'd2, 7'd0, 32'hAAAA_0001)) begin
                errors++;
                $display("FAIL bp_hold %0d: got ack %b vld %b out %h want 0 1 %h", i, din_ack,
                         pkt_vld, pkt_out, mk_pkt(5'd7, 4'd2, 7'd0, 32'hAAAA_0001));
            end
            tick();
        end
        din_vld = 1'b0;
        pkt_rdy = 1'b1;
        checks++;
        if (credit_cnt !== 8'd126) begin
            errors++;
            $display("FAIL bp_credit: got %0d want 126", credit_cnt);
        end
        tick();
        checks++;
        if (pkt_vld !== 1'b1 || pkt_out !== mk_pkt(5'd7, 4'd2, 7'd1, 32'hBBBB_0002)) begin
            errors++;
            $display("FAIL bp_drain1: got vld %b out %h want 1 %h", pkt_vld, pkt_out,
                     mk_pkt(5'd7, 4'd2, 7'd1, 32'hBBBB_0002));
        end
        tick();
        checks++;
        if (pkt_vld !== 1'b0 || pkt_out !== 49'd0) begin
            errors++;
            $display("FAIL bp_empty: got vld %b out %h want 0 0", pkt_vld, pkt_out);
        end
    endtask

    task automatic test_saturate;
        do_reset();
        do_cfg(5'd5, 4'd3);
        pkt_rdy = 1'b1;
        din     = 32'd11;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        checks++;
        if (credit_cnt !== 8'd127) begin
            errors++;
            $display("FAIL sat_pre: got %0d want 127", credit_cnt);
        end
        do_cfg(5'd9, 4'd7);
        din        = 32'd22;
        din_vld    = 1'b1;
        credit_upd = 1'b1;
        #1;
        checks++;
        if (din_ack !== 1'b1) begin
            errors++;
            $display("FAIL sat_ack: got %b want 1", din_ack);
        end
        tick();
        din_vld    = 1'b0;
        credit_upd = 1'b0;
        checks++;
        if (credit_cnt !== 8'd128) begin
            errors++;
            $display("FAIL sat_credit: got %0d want 128", credit_cnt);
        end
        checks++;
        if (pkt_out !== mk_pkt(5'd9, 4'd7, 7'd1, 32'd22)) begin
            errors++;
            $display("FAIL sat_relatch: got %h want %h", pkt_out, mk_pkt(5'd9, 4'd7, 7'd1, 32'd22));
        end
        credit_upd = 1'b1;
        tick();
        credit_upd = 1'b0;
        checks++;
        if (credit_cnt !== 8'd128) begin
            errors++;
            $display("FAIL sat_full_upd: got %0d want 128", credit_cnt);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        do_cfg(5'd3, 4'd4);
        pkt_rdy = 1'b0;
        din_vld = 1'b1;
        din     = 32'h0000_00A1;
        tick();
        din = 32'h0000_00A2;
        tick();
        checks++;
        if (pkt_vld !== 1'b1 || credit_cnt !== 8'd126) begin
            errors++;
            $display("FAIL mid_pre: got vld %b credit %0d want 1 126", pkt_vld, credit_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (pkt_vld !== 1'b0 || pkt_out !== 49'd0 || credit_cnt !== 8'd128 || din_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got vld %b out %h credit %0d ack %b want 0 0 128 0",
                     pkt_vld, pkt_out, credit_cnt, din_ack);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (din_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_uncfg: got %b want 0", din_ack);
        end
        do_cfg(5'd3, 4'd4);
        din     = 32'h0000_00B3;
        pkt_rdy = 1'b1;
        #1;
        checks++;
        if (din_ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack: got %b want 1", din_ack);
        end
        tick();
        din_vld = 1'b0;
        checks++;
        if (pkt_out !== mk_pkt(5'd3, 4'd4, 7'd0, 32'h0000_00B3)) begin
            errors++;
            $display("FAIL mid_addr: got %h want %h", pkt_out, mk_pkt(5'd3, 4'd4, 7'd0, 32'h0000_00B3));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/leaf_out_packetizer.md
Name: leaf_out_packetizer

Overview:
- Sits directly downstream of an HLS operator output port (ap_vld/ap_ack handshake, 32-bit payload).
- Turns each accepted word into a 49-bit BFT packet stamped with the configured destination leaf, port and a write address.
- Gates traffic on destination credit (free space); credit is replenished by freespace-update pulses.
- Runs entirely in the user clock domain; feeds the leaf interface's user-to-BFT path.

Parameters:
- PACKET_BITS, 49, packet width = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
- PAYLOAD_BITS, 32, data word width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, destination buffer address width; initial and maximum credit = 2^NUM_ADDR_BITS
- FREESPACE_UPDATE_SIZE, 64, credit added per update pulse

Ports:
- clk_user  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- din  in  PAYLOAD_BITS  operator output data
- din_vld  in  1  operator data valid (ap_vld)
- din_ack  out  1  accept strobe (ap_ack), combinational
- cfg_wr  in  1  one-cycle config strobe
- cfg_dst_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_dst_port  in  NUM_PORT_BITS  destination port
- credit_upd  in  1  one-cycle freespace-update pulse
- pkt_out  out  PACKET_BITS  packet to interface
- pkt_vld  out  1  packet valid
- pkt_rdy  in  1  interface ready; transfer when pkt_vld & pkt_rdy
- credit_cnt  out  NUM_ADDR_BITS+1  current credit, debug

Behaviour:
- Reset, asynchronous: state=UNCFG; credit=2^NUM_ADDR_BITS (128); addr=0; FIFO empty; din_ack=0; pkt_vld=0; pkt_out=0.
- FSM states:
  - UNCFG: no acceptance. Goes to RUN on cfg_wr, latching leaf/port.
  - RUN: accepts when FIFO not full and credit>0. Goes to CREDIT_WAIT when credit reaches 0 after a send without a same-cycle update.
  - CREDIT_WAIT: no acceptance. Returns to RUN on credit_upd.
- cfg_wr in RUN/CREDIT_WAIT: relatch leaf/port, effective for the next accepted word. addr is not reset.
- din_ack = din_vld & (state==RUN) & credit!=0 & fifo_count<2. Combinational, same cycle as acceptance.
- Accepted word forms packet {1'b1, leaf, port, addr, din}:
  - bit 48 valid; [47:43] leaf; [42:39] port; [38:32] addr; [31:0] payload.
  - Packet is written to a 2-entry FIFO.
  - addr increments mod 2^NUM_ADDR_BITS (127 -> 0).
  - credit decrements by 1.
- Latency: a word accepted in cycle N appears on pkt_out with pkt_vld=1 in cycle N+1 (FIFO empty, no bypass).
- pkt_out and pkt_vld hold stable while pkt_vld & !pkt_rdy. pkt_out = 0 when empty.
- FIFO: simultaneous push and pop when full is forbidden by din_ack. Push and pop in the same cycle at count 1 leaves count 1.
- Credit arithmetic:
  - next = credit − accept + (credit_upd ? FREESPACE_UPDATE_SIZE : 0), saturating at 2^NUM_ADDR_BITS.
  - Simultaneous accept and update nets (127 −1 +64 -> 128 after saturation).
- Reset mid-operation: FIFO contents discarded, credit and addr restored immediately. The in-flight packet is lost by design.

Decomposition:
- Shared package leaf_pkg:
  - packet field offsets/widths (VALID_BIT, LEAF_MSB/LSB, PORT_MSB/LSB, ADDR_MSB/LSB)
  - FSM state enum (UNCFG, RUN, CREDIT_WAIT)
  - MAX_CREDIT constant
- One sub-module: leaf_pkt_fifo2, a 2-entry PACKET_BITS-wide FIFO with count, async reset.

Test Plan:
- Reset, din_vld=1, no cfg_wr for 10 cycles -> din_ack stays 0, pkt_vld stays 0, credit_cnt=128.
- cfg_wr leaf=5 port=3, din=0xDEADBEEF, pkt_rdy=1 -> din_ack same cycle; next cycle pkt_out=0x1_5_3_00_DEADBEEF fields (bit48=1, leaf=5, port=3, addr=0); credit_cnt=127.
- Stream 130 words, pkt_rdy=1, no updates -> exactly 128 accepted, addr sequence 0..127, then CREDIT_WAIT with din_ack=0; one credit_upd -> 64 more accepted, first with addr=0.
- pkt_rdy=0 with continuous din_vld -> two words accepted, then din_ack=0; pkt_out unchanged for 20 cycles; raise pkt_rdy -> packets drain in order.
- credit=127, accept and credit_upd in the same cycle -> credit_cnt=128 (saturated), not 190.
- Assert reset while FIFO holds 2 packets -> pkt_vld=0 immediately; credit_cnt=128; addr restarts at 0; state UNCFG.
